// File: rtl/oam_dma_ctrl_pkg.sv
// Shared constants and FSM encoding for the OAM sprite DMA controller.
package oam_dma_ctrl_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int REG_WIDTH  = 8;

  localparam logic [ADDR_WIDTH-1:0] OAM_DMA_REG = 16'h4014;
  localparam logic [ADDR_WIDTH-1:0] PPU_OAMDATA = 16'h2004;

  typedef enum logic [2:0] {
    DMA_IDLE  = 3'd0,
    DMA_HALT  = 3'd1,
    DMA_ALIGN = 3'd2,
    DMA_READ  = 3'd3,
    DMA_WRITE = 3'd4
  } dma_state_t;

endpackage

// File: rtl/oam_dma_ctrl_if.sv
// CPU-side and system-bus-side signals of the OAM DMA stage.
interface oam_dma_ctrl_if;
  import oam_dma_ctrl_pkg::*;

  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [REG_WIDTH-1:0]  cpu_dout;
  logic                  cpu_r_w_n;
  logic                  cpu_rdy;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [REG_WIDTH-1:0]  bus_wdata;
  logic                  bus_r_w_n;
  logic [REG_WIDTH-1:0]  bus_rdata;
  logic                  dma_active;
  logic                  dma_done;

  modport slave (
    input  cpu_addr, cpu_dout, cpu_r_w_n, bus_rdata,
    output cpu_rdy, bus_addr, bus_wdata, bus_r_w_n, dma_active, dma_done
  );

  modport master (
    output cpu_addr, cpu_dout, cpu_r_w_n, bus_rdata,
    input  cpu_rdy, bus_addr, bus_wdata, bus_r_w_n, dma_active, dma_done
  );

endinterface

// File: rtl/oam_dma_ctrl.sv
// CPU bus passthrough with $4014-triggered 256-byte sprite DMA into OAMDATA.
// Define OAM_DMA_ALIGN_EN to insert one ALIGN cycle when HALT falls on an odd cycle.
module oam_dma_ctrl
  import oam_dma_ctrl_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] DMA_REG_ADDR  = OAM_DMA_REG,
  parameter logic [ADDR_WIDTH-1:0] OAM_DATA_ADDR = PPU_OAMDATA
) (
  input  logic           phi0,
  input  logic           reset,
  oam_dma_ctrl_if.slave  bif
);

  dma_state_t           r_state;
  logic                 r_parity;
  logic                 r_cpu_rdy;
  logic                 r_dma_done;
  logic [REG_WIDTH-1:0] r_idx;
  logic [REG_WIDTH-1:0] r_page;
  logic [REG_WIDTH-1:0] r_data;
  logic                 w_trigger;

  // Only a genuine CPU write starts a DMA; reads of the register are harmless.
  assign w_trigger = (bif.cpu_r_w_n == 1'b0) && (bif.cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge phi0) begin
    if (reset) begin
      r_state    <= DMA_IDLE;
      r_parity   <= 1'b0;
      r_cpu_rdy  <= 1'b1;
      r_dma_done <= 1'b0;
      r_idx      <= '0;
      r_page     <= '0;
      r_data     <= '0;
    end else begin
      r_parity   <= ~r_parity;
      r_dma_done <= 1'b0;
      case (r_state)
        DMA_IDLE: begin
          if (w_trigger) begin
            r_page    <= bif.cpu_dout;
            r_idx     <= '0;
            r_cpu_rdy <= 1'b0;
            r_state   <= DMA_HALT;
          end
        end
        DMA_HALT: begin
`ifdef OAM_DMA_ALIGN_EN
          r_state <= r_parity ? DMA_ALIGN : DMA_READ;
`else
          r_state <= DMA_READ;
`endif
        end
        DMA_ALIGN: r_state <= DMA_READ;
        DMA_READ: begin
          r_data  <= bif.bus_rdata;
          r_state <= DMA_WRITE;
        end
        DMA_WRITE: begin
          // idx wraps within the page, so the source never leaves $XX00-$XXFF.
          r_idx <= r_idx + 8'd1;
          if (r_idx == 8'hFF) begin
            r_state    <= DMA_IDLE;
            r_cpu_rdy  <= 1'b1;
            r_dma_done <= 1'b1;
          end else begin
            r_state <= DMA_READ;
          end
        end
        default: r_state <= DMA_IDLE;
      endcase
    end
  end

  always_comb begin
    bif.bus_addr  = bif.cpu_addr;
    bif.bus_wdata = bif.cpu_dout;
    bif.bus_r_w_n = bif.cpu_r_w_n;
    case (r_state)
      DMA_READ: begin
        bif.bus_addr  = {r_page, r_idx};
        bif.bus_r_w_n = 1'b1;
      end
      DMA_WRITE: begin
        bif.bus_addr  = OAM_DATA_ADDR;
        bif.bus_wdata = r_data;
        bif.bus_r_w_n = 1'b0;
      end
      default: ;
    endcase
  end

  assign bif.cpu_rdy    = r_cpu_rdy;
  assign bif.dma_done   = r_dma_done;
  assign bif.dma_active = (r_state != DMA_IDLE);

endmodule
